// File: rtl/dec_pkg.sv
// Shared definitions for buffered decoders: skid-buffer occupancy states
// and the polarity/enable constants used by the decode stage.
package dec_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  localparam logic ACT_HIGH   = 1'b1;
  localparam logic ACT_LOW    = 1'b0;
  localparam logic EN_ENABLE  = 1'b1;
  localparam logic EN_DISABLE = 1'b0;

endpackage

// File: rtl/pri_dec_buf_if.sv
// Request/response bundle for the buffered decoder. The slave view is the
// decoder itself; the master view is whoever feeds and drains it.
interface pri_dec_buf_if #(
  parameter int OUT = 16,
  parameter int IN  = $clog2(OUT)
);
  logic           in_valid;
  logic           in_ready;
  logic           in_en;
  logic [IN-1:0]  in;
  logic           out_valid;
  logic           out_ready;
  logic [OUT-1:0] out;
  logic           out_err;

  modport slave (
    input  in_valid, in_en, in, out_ready,
    output in_ready, out_valid, out, out_err
  );

  modport master (
    output in_valid, in_en, in, out_ready,
    input  in_ready, out_valid, out, out_err
  );
endinterface

// File: rtl/pri_dec.sv
// Combinational binary-to-one-hot decode with selectable active level.
// Out-of-range indices produce an all-inactive vector and flag err_o.
module pri_dec
  import dec_pkg::*;
#(
  parameter int   OUT = 16,
  parameter int   IN  = $clog2(OUT),
  parameter logic ACT = ACT_HIGH
) (
  input  logic           en_i,
  input  logic [IN-1:0]  idx_i,
  output logic [OUT-1:0] vec_o,
  output logic           err_o
);

  logic [31:0] idx_ext;

  assign idx_ext = 32'(idx_i);

  // Drive the matching bit to ACT; everything else stays inactive.
  always_comb begin
    vec_o = {OUT{~ACT}};
    err_o = 1'b0;
    if (en_i == EN_ENABLE) begin
      if (idx_ext >= 32'(OUT)) begin
        err_o = 1'b1;
      end else begin
        for (int i = 0; i < OUT; i++) begin
          if (idx_ext == 32'(i)) vec_o[i] = ACT;
        end
      end
    end
  end

endmodule

// File: rtl/pri_dec_buf.sv
// Decoder with a 2-entry skid buffer on the output. Decode happens at the
// input so both registers hold finished vectors; in_ready depends only on
// registered state, so there is no combinational path from out_ready.
//
//   state | meaning
//   ------+-------------------------------------------
//   EMPTY | no entry held, out is all inactive
//   ONE   | main register valid and driving out
//   FULL  | main valid plus one overflow entry in skid
module pri_dec_buf
  import dec_pkg::*;
#(
  parameter int   OUT = 16,
  parameter int   IN  = $clog2(OUT),
  parameter logic ACT = ACT_HIGH
) (
  input  logic           clk,
  input  logic           reset_,
  pri_dec_buf_if.slave   bus
);

  localparam logic [OUT-1:0] IDLE_VEC = {OUT{~ACT}};

  buf_state_e     state_q, state_d;
  logic [OUT-1:0] main_vec_q, main_vec_d;
  logic           main_err_q, main_err_d;
  logic [OUT-1:0] skid_vec_q, skid_vec_d;
  logic           skid_err_q, skid_err_d;

  logic [OUT-1:0] new_vec;
  logic           new_err;
  logic           in_ready;
  logic           out_valid;
  logic           accept;
  logic           emit;

  pri_dec #(
    .OUT (OUT),
    .IN  (IN),
    .ACT (ACT)
  ) u_dec (
    .en_i  (bus.in_en),
    .idx_i (bus.in),
    .vec_o (new_vec),
    .err_o (new_err)
  );

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.in_valid & in_ready;
  assign emit      = out_valid & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out       = main_vec_q;
  assign bus.out_err   = main_err_q;

  // Next-state and register loads; main is cleared when it empties so out
  // already reads inactive whenever out_valid is low.
  always_comb begin
    state_d    = state_q;
    main_vec_d = main_vec_q;
    main_err_d = main_err_q;
    skid_vec_d = skid_vec_q;
    skid_err_d = skid_err_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          main_vec_d = new_vec;
          main_err_d = new_err;
        end
      end
      ONE: begin
        if (accept && !emit) begin
          state_d    = FULL;
          skid_vec_d = new_vec;
          skid_err_d = new_err;
        end else if (!accept && emit) begin
          state_d    = EMPTY;
          main_vec_d = IDLE_VEC;
          main_err_d = 1'b0;
        end else if (accept && emit) begin
          main_vec_d = new_vec;
          main_err_d = new_err;
        end
      end
      FULL: begin
        if (emit) begin
          state_d    = ONE;
          main_vec_d = skid_vec_q;
          main_err_d = skid_err_q;
          skid_vec_d = IDLE_VEC;
          skid_err_d = 1'b0;
        end
      end
      default: begin
        state_d    = EMPTY;
        main_vec_d = IDLE_VEC;
        main_err_d = 1'b0;
        skid_vec_d = IDLE_VEC;
        skid_err_d = 1'b0;
      end
    endcase
  end

  // State and data registers; reset drops both entries at once.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= EMPTY;
      main_vec_q <= IDLE_VEC;
      main_err_q <= 1'b0;
      skid_vec_q <= IDLE_VEC;
      skid_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_vec_q <= main_vec_d;
      main_err_q <= main_err_d;
      skid_vec_q <= skid_vec_d;
      skid_err_q <= skid_err_d;
    end
  end

endmodule

// File: tb/tb_pri_dec_buf.sv
// Directed bench for pri_dec_buf: default build, active-low build and a
// 10-wide build sharing one clock and reset.
module tb_pri_dec_buf;
  import dec_pkg::*;

  logic clk;
  logic reset_;
  int   n_chk;
  int   n_err;

  pri_dec_buf_if #(.OUT(16)) b16 ();
  pri_dec_buf_if #(.OUT(16)) blo ();
  pri_dec_buf_if #(.OUT(10)) b10 ();

  pri_dec_buf #(.OUT(16)) dut16 (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (b16)
  );

  pri_dec_buf #(.OUT(16), .ACT(ACT_LOW)) dutlo (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (blo)
  );

  pri_dec_buf #(.OUT(10)) dut10 (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (b10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    reset_ = 1'b0;
    b16.in_valid = 1'b0; b16.in_en = 1'b0; b16.in = '0; b16.out_ready = 1'b0;
    blo.in_valid = 1'b0; blo.in_en = 1'b0; blo.in = '0; blo.out_ready = 1'b0;
    b10.in_valid = 1'b0; b10.in_en = 1'b0; b10.in = '0; b10.out_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(b16.out_valid), 32'd0);
    chk("rst_in_ready",  32'(b16.in_ready),  32'd1);
    chk("rst_out",       32'(b16.out),       32'h0000);
    chk("rst_err",       32'(b16.out_err),   32'd0);
    chk("rst_lo_out",    32'(blo.out),       32'hFFFF);

    // Case 1: single request, one-cycle latency
    reset_ = 1'b1;
    @(negedge clk);
    b16.in = 4'd5; b16.in_en = 1'b1; b16.in_valid = 1'b1;
    @(negedge clk);
    b16.in_valid = 1'b0;
    chk("c1_out",       32'(b16.out),       32'h0020);
    chk("c1_out_valid", 32'(b16.out_valid), 32'd1);
    b16.out_ready = 1'b1;
    @(negedge clk);
    chk("c1_drain_valid", 32'(b16.out_valid), 32'd0);
    chk("c1_drain_out",   32'(b16.out),       32'h0000);

    // Case 2: stream 0..15 at full rate
    for (int i = 0; i < 16; i++) begin
      b16.in = 4'(i); b16.in_en = 1'b1; b16.in_valid = 1'b1;
      chk($sformatf("c2_ready_%0d", i), 32'(b16.in_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("c2_out_%0d", i),   32'(b16.out),       32'd1 << i);
      chk($sformatf("c2_valid_%0d", i), 32'(b16.out_valid), 32'd1);
    end
    b16.in_valid = 1'b0;
    @(negedge clk);
    chk("c2_end_valid", 32'(b16.out_valid), 32'd0);

    // in_en low gives an all-inactive but valid entry
    b16.in = 4'd7; b16.in_en = 1'b0; b16.in_valid = 1'b1; b16.out_ready = 1'b0;
    @(negedge clk);
    b16.in_valid = 1'b0;
    chk("dis_out",   32'(b16.out),       32'h0000);
    chk("dis_valid", 32'(b16.out_valid), 32'd1);
    chk("dis_err",   32'(b16.out_err),   32'd0);
    b16.out_ready = 1'b1;
    @(negedge clk);
    chk("dis_drain", 32'(b16.out_valid), 32'd0);

    // Case 3: back-pressure fills skid, then drains in order
    b16.out_ready = 1'b0;
    b16.in = 4'd3; b16.in_en = 1'b1; b16.in_valid = 1'b1;
    @(negedge clk);
    chk("c3_one_out",   32'(b16.out),      32'h0008);
    chk("c3_one_ready", 32'(b16.in_ready), 32'd1);
    b16.in = 4'd9;
    @(negedge clk);
    chk("c3_full_ready", 32'(b16.in_ready), 32'd0);
    chk("c3_full_out",   32'(b16.out),      32'h0008);
    b16.in = 4'd1;
    repeat (2) begin
      @(negedge clk);
      chk("c3_stable_out",   32'(b16.out),       32'h0008);
      chk("c3_stable_valid", 32'(b16.out_valid), 32'd1);
      chk("c3_stable_ready", 32'(b16.in_ready),  32'd0);
    end
    b16.in_valid = 1'b0;
    b16.out_ready = 1'b1;
    chk("c3_emit0", 32'(b16.out), 32'h0008);
    @(negedge clk);
    chk("c3_emit1",       32'(b16.out),       32'h0200);
    chk("c3_emit1_valid", 32'(b16.out_valid), 32'd1);
    chk("c3_emit1_ready", 32'(b16.in_ready),  32'd1);
    @(negedge clk);
    chk("c3_empty", 32'(b16.out_valid), 32'd0);

    // Case 6: asynchronous reset while FULL
    b16.out_ready = 1'b0;
    b16.in = 4'd1; b16.in_valid = 1'b1;
    @(negedge clk);
    b16.in = 4'd2;
    @(negedge clk);
    b16.in_valid = 1'b0;
    chk("c6_full", 32'(b16.in_ready), 32'd0);
    #2 reset_ = 1'b0;
    #1;
    chk("c6_rst_valid", 32'(b16.out_valid), 32'd0);
    chk("c6_rst_ready", 32'(b16.in_ready),  32'd1);
    chk("c6_rst_out",   32'(b16.out),       32'h0000);
    @(negedge clk);
    reset_ = 1'b1;
    b16.out_ready = 1'b1;
    b16.in = 4'd7; b16.in_valid = 1'b1;
    @(negedge clk);
    b16.in_valid = 1'b0;
    chk("c6_first_out",   32'(b16.out),       32'h0080);
    chk("c6_first_valid", 32'(b16.out_valid), 32'd1);
    @(negedge clk);
    chk("c6_drained", 32'(b16.out_valid), 32'd0);

    // Case 4: active-low polarity
    blo.out_ready = 1'b0;
    blo.in = 4'd0; blo.in_en = 1'b1; blo.in_valid = 1'b1;
    @(negedge clk);
    blo.in_valid = 1'b0;
    chk("c4_lo_out", 32'(blo.out),     32'hFFFE);
    chk("c4_lo_err", 32'(blo.out_err), 32'd0);
    blo.out_ready = 1'b1;
    @(negedge clk);
    chk("c4_lo_idle_out",   32'(blo.out),       32'hFFFF);
    chk("c4_lo_idle_valid", 32'(blo.out_valid), 32'd0);
    blo.out_ready = 1'b0;
    blo.in_en = 1'b0; blo.in_valid = 1'b1;
    @(negedge clk);
    blo.in_valid = 1'b0;
    chk("c4_dis_out",   32'(blo.out),       32'hFFFF);
    chk("c4_dis_valid", 32'(blo.out_valid), 32'd1);
    chk("c4_dis_err",   32'(blo.out_err),   32'd0);

    // Case 5: OUT=10, out-of-range index
    b10.out_ready = 1'b1;
    b10.in = 4'd12; b10.in_en = 1'b1; b10.in_valid = 1'b1;
    @(negedge clk);
    chk("c5_oor_out",   32'(b10.out),       32'h000);
    chk("c5_oor_err",   32'(b10.out_err),   32'd1);
    chk("c5_oor_valid", 32'(b10.out_valid), 32'd1);
    b10.in = 4'd9;
    @(negedge clk);
    b10.in_valid = 1'b0;
    chk("c5_top_out", 32'(b10.out),     32'h200);
    chk("c5_top_err", 32'(b10.out_err), 32'd0);
    @(negedge clk);
    chk("c5_idle_valid", 32'(b10.out_valid), 32'd0);
    chk("c5_idle_err",   32'(b10.out_err),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
